// File: rtl/addr_unit.sv
// Address and instruction-register unit for the 8-bit core: PC, SP, MAR, IR and
// the CALL target latch, all updated on the rising clock edge keyed on the FSM state.

package addr_unit_pkg;
    localparam logic [7:0] STATE_NEXT       = 8'd0;
    localparam logic [7:0] STATE_FETCH_PC   = 8'd1;
    localparam logic [7:0] STATE_FETCH_INST = 8'd2;
    localparam logic [7:0] STATE_LOAD_ADDR  = 8'd3;
    localparam logic [7:0] STATE_SET_MAR    = 8'd4;
    localparam logic [7:0] STATE_SET_REG    = 8'd5;
    localparam logic [7:0] STATE_STORE_PC   = 8'd6;
    localparam logic [7:0] STATE_TMP_JUMP   = 8'd7;
    localparam logic [7:0] STATE_JUMP       = 8'd8;
    localparam logic [7:0] STATE_FETCH_SP   = 8'd9;
    localparam logic [7:0] STATE_INC_SP     = 8'd10;
    localparam logic [7:0] STATE_RET        = 8'd11;
    localparam logic [7:0] STATE_HALT       = 8'd12;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOV  = 8'h10;
    localparam logic [7:0] OP_PUSH = 8'h20;
    localparam logic [7:0] OP_CALL = 8'h30;
    localparam logic [7:0] OP_JMP  = 8'h40;
    localparam logic [7:0] OP_POP  = 8'h50;
    localparam logic [7:0] OP_RET  = 8'h60;
endpackage

module addr_unit
    import addr_unit_pkg::*;
#(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [7:0] STACK_TOP = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] state,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] reg_data,
    input  logic       jump_taken,
    output logic [7:0] opcode,
    output logic [7:0] mem_addr,
    output logic [7:0] pc,
    output logic [7:0] sp,
    output logic       pc_to_bus,
    output logic       halted,
    output logic       stack_fault
);

    logic [7:0] pc_q, pc_d, sp_q, sp_d, mar_q, mar_d, ir_q, ir_d, tmp_q, tmp_d;
    logic       call_phase_q, call_phase_d, halted_q, halted_d, fault_q, fault_d;
    logic [7:0] sp_dec_s, sp_inc_s;

    assign sp_dec_s = sp_q - 8'd1;
    assign sp_inc_s = sp_q + 8'd1;

    // Next-state decode; a halted unit freezes everything except reset.
    always_comb begin
        pc_d         = pc_q;
        sp_d         = sp_q;
        mar_d        = mar_q;
        ir_d         = ir_q;
        tmp_d        = tmp_q;
        call_phase_d = call_phase_q;
        halted_d     = halted_q;
        fault_d      = fault_q;
        if (!halted_q) begin
            case (state)
                STATE_FETCH_PC: begin
                    if (call_phase_q) begin
                        mar_d = sp_q;
                        sp_d  = sp_dec_s;
                        if (sp_q == 8'h00) fault_d = 1'b1;
                    end else begin
                        mar_d = pc_q;
                        pc_d  = pc_q + 8'd1;
                    end
                end
                STATE_FETCH_INST: ir_d  = mem_rdata;
                STATE_LOAD_ADDR:  mar_d = mem_rdata;
                STATE_SET_MAR:    mar_d = reg_data;
                STATE_SET_REG: begin
                    if (ir_q == OP_CALL) begin
                        tmp_d        = mem_rdata;
                        call_phase_d = 1'b1;
                    end else begin
                        tmp_d = tmp_q;
                    end
                end
                STATE_TMP_JUMP: begin
                    pc_d         = tmp_q;
                    call_phase_d = 1'b0;
                end
                STATE_JUMP: begin
                    if (jump_taken) pc_d = mem_rdata;
                    else            pc_d = pc_q;
                end
                STATE_FETCH_SP: begin
                    mar_d = sp_q;
                    if (ir_q == OP_PUSH) begin
                        sp_d = sp_dec_s;
                        if (sp_q == 8'h00) fault_d = 1'b1;
                    end else begin
                        sp_d = sp_q;
                    end
                end
                STATE_INC_SP: begin
                    sp_d = sp_inc_s;
                    if (sp_q == STACK_TOP) fault_d = 1'b1;
                end
                STATE_RET:  pc_d         = mem_rdata;
                STATE_HALT: halted_d     = 1'b1;
                STATE_NEXT: call_phase_d = 1'b0;
                default:    pc_d         = pc_q;
            endcase
        end else begin
            halted_d = 1'b1;
        end
    end

    // Register bank with synchronous reset taking priority over any state action.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            sp_q         <= STACK_TOP;
            mar_q        <= 8'h00;
            ir_q         <= OP_NOP;
            tmp_q        <= 8'h00;
            call_phase_q <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            mar_q        <= mar_d;
            ir_q         <= ir_d;
            tmp_q        <= tmp_d;
            call_phase_q <= call_phase_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
        end
    end

    assign opcode      = ir_q;
    assign mem_addr    = mar_q;
    assign pc          = pc_q;
    assign sp          = sp_q;
    assign halted      = halted_q;
    assign stack_fault = fault_q;
    assign pc_to_bus   = (state == STATE_STORE_PC);

endmodule
